m68k_bus_responder: RTL and testbench

- 68000 bus target that answers Amiga-initiated bus cycles falling inside a configurable address window.
- Decodes AS/UDS/LDS/RnW and forwards each matched cycle to the Pi-side register logic over a valid/ready request channel.
- Takes back a response (read data or write ack) and terminates the cycle with DTACK, or with BERR on timeout.
- Sits beside the bus-master engine in the PiStorm16 top level and shares the same bus pins via open-drain/OE control.

---
 rtl/m68k_bus_responder.sv | 204 ++++++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: forwards Amiga cycles hitting an address window to the Pi-side request channel.
// Latency: request raised on the first synced CLK_7M fall with AS+DS low; DTACK follows the response on the next synced CLK_7M rise.
// Backpressure: req_* held stable until req_ready; BERR once TIMEOUT_CYCLES 7M falls pass without a response.
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR      = 24'hE90000,
    parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        sys_clk,
    input  logic        nRESET,
    input  logic        CLK_7M,
    input  logic        nRESET_BUS,
    input  logic        nAS_IN,
    input  logic        RnW_IN,
    input  logic        nUDS_IN,
    input  logic        nLDS_IN,
    input  logic [22:0] A_IN,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK_OE,
    output logic        nBERR_OE,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [23:0] req_addr,
    output logic        req_read,
    output logic [1:0]  req_be,
    output logic [15:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data,
    output logic        bus_error
);

    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [23:0] CMP_MASK = ADDR_MASK & 24'hFFFFFE;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, ACK, WAIT_NEGATE} state_t;

    logic [1:0] clk7_sync, as_sync, rnw_sync, uds_sync, lds_sync, brst_sync;
    logic       clk7_prev;

    // Strobes reset to their inactive (high) level so nothing decodes straight out of reset.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            clk7_sync <= 2'b00;
            as_sync   <= 2'b11;
            rnw_sync  <= 2'b11;
            uds_sync  <= 2'b11;
            lds_sync  <= 2'b11;
            brst_sync <= 2'b00;
            clk7_prev <= 1'b0;
        end else begin
            clk7_sync <= {clk7_sync[0], CLK_7M};
            as_sync   <= {as_sync[0], nAS_IN};
            rnw_sync  <= {rnw_sync[0], RnW_IN};
            uds_sync  <= {uds_sync[0], nUDS_IN};
            lds_sync  <= {lds_sync[0], nLDS_IN};
            brst_sync <= {brst_sync[0], nRESET_BUS};
            clk7_prev <= clk7_sync[1];
        end
    end

    logic clk7_rise, clk7_fall, as_n, rnw, uds_n, lds_n, brst_n;
    logic addr_hit, decode, timeout_hit;

    assign clk7_rise = ~clk7_prev & clk7_sync[1];
    assign clk7_fall = clk7_prev & ~clk7_sync[1];
    assign as_n      = as_sync[1];
    assign rnw       = rnw_sync[1];
    assign uds_n     = uds_sync[1];
    assign lds_n     = lds_sync[1];
    assign brst_n    = brst_sync[1];

    assign addr_hit = (({A_IN, 1'b0} & CMP_MASK) == (BASE_ADDR & CMP_MASK));
    assign decode   = clk7_fall && !as_n && (!uds_n || !lds_n) && addr_hit;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_cnt_last;
    logic [15:0]   d_out_nxt, req_wdata_nxt;
    logic [23:0]   req_addr_nxt;
    logic [1:0]    req_be_nxt;
    logic          d_oe_nxt, dtack_nxt, berr_nxt, req_valid_nxt, req_read_nxt, bus_error_nxt;

    assign timeout_cnt_last = (cnt == TO_LAST);
    assign timeout_hit      = clk7_fall && timeout_cnt_last;

    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
            nDTACK_OE <= 1'b0;
            nBERR_OE  <= 1'b0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_read  <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
            bus_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            D_OUT     <= d_out_nxt;
            D_OE      <= d_oe_nxt;
            nDTACK_OE <= dtack_nxt;
            nBERR_OE  <= berr_nxt;
            req_valid <= req_valid_nxt;
            req_addr  <= req_addr_nxt;
            req_read  <= req_read_nxt;
            req_be    <= req_be_nxt;
            req_wdata <= req_wdata_nxt;
            bus_error <= bus_error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        d_out_nxt     = D_OUT;
        d_oe_nxt      = D_OE;
        dtack_nxt     = nDTACK_OE;
        berr_nxt      = nBERR_OE;
        req_valid_nxt = req_valid;
        req_addr_nxt  = req_addr;
        req_read_nxt  = req_read;
        req_be_nxt    = req_be;
        req_wdata_nxt = req_wdata;
        bus_error_nxt = 1'b0;

        // Bus reset overrides everything and parks the block in IDLE while held.
        if (!brst_n) begin
            state_nxt     = IDLE;
            req_valid_nxt = 1'b0;
            d_oe_nxt      = 1'b0;
            dtack_nxt     = 1'b0;
            berr_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (decode) begin
                        state_nxt     = REQ;
                        cnt_nxt       = '0;
                        req_valid_nxt = 1'b1;
                        req_addr_nxt  = {A_IN, 1'b0};
                        req_read_nxt  = rnw;
                        req_be_nxt    = {~uds_n, ~lds_n};
                        req_wdata_nxt = rnw ? 16'h0000 : D_IN;
                    end
                end
                REQ, WAIT_RSP: begin
                    if (as_n) begin
                        state_nxt     = IDLE;
                        req_valid_nxt = 1'b0;
                        d_oe_nxt      = 1'b0;
                        dtack_nxt     = 1'b0;
                        berr_nxt      = 1'b0;
                    end else if (timeout_hit) begin
                        // A response landing on this same cycle is intentionally dropped.
                        state_nxt     = WAIT_NEGATE;
                        cnt_nxt       = cnt + CW'(1);
                        req_valid_nxt = 1'b0;
                        berr_nxt      = 1'b1;
                        bus_error_nxt = 1'b1;
                    end else begin
                        if (clk7_fall) begin
                            cnt_nxt = cnt + CW'(1);
                        end
                        if (state == REQ) begin
                            if (req_ready) begin
                                req_valid_nxt = 1'b0;
                                state_nxt     = WAIT_RSP;
                            end
                        end else if (rsp_valid) begin
                            if (req_read) begin
                                d_out_nxt = rsp_data;
                                d_oe_nxt  = 1'b1;
                            end
                            state_nxt = ACK;
                        end
                    end
                end
                ACK: begin
                    if (clk7_rise) begin
                        dtack_nxt = 1'b1;
                        state_nxt = WAIT_NEGATE;
                    end
                end
                WAIT_NEGATE: begin
                    if (as_n) begin
                        dtack_nxt = 1'b0;
                        berr_nxt  = 1'b0;
                        d_oe_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Randomized bus-cycle bench for m68k_bus_responder: stimulus queues expectations, a monitor compares.
module tb_m68k_bus_responder;

    localparam logic [23:0] BASE = 24'hE90000;
    localparam logic [23:0] MASK = 24'hFF0000 & 24'hFFFFFE;

    logic        sys_clk, nRESET, CLK_7M, nRESET_BUS;
    logic        nAS_IN, RnW_IN, nUDS_IN, nLDS_IN;
    logic [22:0] A_IN;
    logic [15:0] D_IN, D_OUT, rsp_data;
    logic        D_OE, nDTACK_OE, nBERR_OE, req_valid, req_ready, req_read, rsp_valid, bus_error;
    logic [23:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;

    m68k_bus_responder dut (
        .sys_clk(sys_clk), .nRESET(nRESET), .CLK_7M(CLK_7M), .nRESET_BUS(nRESET_BUS),
        .nAS_IN(nAS_IN), .RnW_IN(RnW_IN), .nUDS_IN(nUDS_IN), .nLDS_IN(nLDS_IN),
        .A_IN(A_IN), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .nDTACK_OE(nDTACK_OE), .nBERR_OE(nBERR_OE),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_read(req_read), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .bus_error(bus_error)
    );

    typedef struct { logic [23:0] addr; bit rd; logic [1:0] be; logic [15:0] wdata; } req_t;
    typedef struct { bit berr; bit rd; logic [15:0] data; } term_t;

    req_t  req_q[$];
    term_t term_q[$];
    int    n_cmp = 0, n_fail = 0;
    int    fall_cnt = 0, rise_cnt = 0, be_cnt = 0;
    bit    cur_read = 1'b0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        CLK_7M = 1'b0;
        #3;
        forever #70 CLK_7M = ~CLK_7M;
    end

    always @(negedge CLK_7M) fall_cnt++;
    always @(posedge CLK_7M) rise_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    logic dtack_prev = 1'b0, berr_prev = 1'b0, doe_prev = 1'b0;
    always @(negedge sys_clk) begin
        req_t  e;
        term_t t;
        if (req_valid) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", req_valid, 0);
            end else begin
                e = req_q[0];
                check("req_fields", {req_addr, req_read, req_be, e.rd ? 16'h0 : req_wdata},
                      {e.addr, e.rd, e.be, e.rd ? 16'h0 : e.wdata});
                if (req_ready) void'(req_q.pop_front());
            end
        end
        if (nDTACK_OE && !dtack_prev) begin
            if (term_q.size() == 0) check("dtack_unexpected", nDTACK_OE, 0);
            else begin
                t = term_q.pop_front();
                check("term_kind_dtack", t.berr, 0);
                check("dtack_doe", D_OE, t.rd);
                if (t.rd) check("dtack_dout", D_OUT, t.data);
            end
        end
        if (nBERR_OE && !berr_prev) begin
            if (term_q.size() == 0) check("berr_unexpected", nBERR_OE, 0);
            else begin
                t = term_q.pop_front();
                check("term_kind_berr", t.berr, 1);
                check("berr_doe", D_OE, 0);
            end
        end
        if (D_OE && !doe_prev) check("doe_only_reads", cur_read, 1);
        if (bus_error) be_cnt++;
        dtack_prev = nDTACK_OE;
        berr_prev  = nBERR_OE;
        doe_prev   = D_OE;
    end

    task automatic release_bus();
        @(posedge CLK_7M);
        #13;
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 check("release_oe", {D_OE, nDTACK_OE, nBERR_OE}, 0);
        @(posedge CLK_7M);
    endtask

    // mode: 0 normal response, 1 no response (timeout), 2 bus reset in WAIT_RSP, 3 nRESET in ACK
    task automatic do_cycle(input logic [23:0] addr, input bit rnw, input logic [1:0] be,
                            input logic [15:0] wdata, input int rdy_dly, input int mode,
                            input logic [15:0] rdata);
        bit    match, quiet;
        int    f0, r0, bec0;
        req_t  rq;
        term_t tm;
        match = ((addr & MASK) == (BASE & MASK));
        if (match) begin
            rq.addr = {addr[23:1], 1'b0}; rq.rd = rnw; rq.be = be; rq.wdata = wdata;
            req_q.push_back(rq);
            if (mode <= 1) begin
                tm.berr = (mode == 1); tm.rd = rnw; tm.data = rdata;
                term_q.push_back(tm);
            end
        end
        cur_read = rnw;
        bec0 = be_cnt;
        @(posedge CLK_7M);
        #7;
        A_IN = addr[23:1]; RnW_IN = rnw; D_IN = rnw ? 16'($urandom) : wdata;
        #20;
        nAS_IN = 1'b0; nUDS_IN = ~be[1]; nLDS_IN = ~be[0];
        f0 = fall_cnt + 1;
        if (!match) begin
            quiet = 1'b1;
            repeat (56) begin
                @(negedge sys_clk);
                if (req_valid | D_OE | nDTACK_OE | nBERR_OE | bus_error) quiet = 1'b0;
            end
            check("nomatch_quiet", quiet, 1);
            release_bus();
            return;
        end
        for (int i = 0; i < 100 && !req_valid; i++) @(posedge sys_clk);
        check("req_seen", req_valid, 1);
        repeat (rdy_dly) @(posedge sys_clk);
        #1 req_ready = 1'b1;
        @(posedge sys_clk);
        #1 req_ready = 1'b0;
        if (mode == 2) begin
            repeat (5) @(posedge sys_clk);
            #2 nRESET_BUS = 1'b0;
            repeat (4) @(posedge sys_clk);
            #1 check("busrst_quiet", {req_valid, D_OE, nDTACK_OE, nBERR_OE}, 0);
            nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
            repeat (3) @(posedge sys_clk);
            nRESET_BUS = 1'b1;
            repeat (4) @(posedge sys_clk);
            @(posedge CLK_7M);
        end else if (mode == 1) begin
            for (int i = 0; i < 1200 && !nBERR_OE; i++) @(negedge sys_clk);
            check("berr_fall_count", fall_cnt - f0, 64);
            @(posedge sys_clk);
            #1 rsp_valid = 1'b1; rsp_data = rdata;
            @(posedge sys_clk);
            #1 rsp_valid = 1'b0;
            repeat (28) @(negedge sys_clk);
            check("late_rsp_ignored", {D_OE, nDTACK_OE, nBERR_OE}, 3'b001);
            check("bus_error_pulses", be_cnt - bec0, 1);
            release_bus();
        end else begin
            @(negedge CLK_7M);
            repeat ($urandom_range(2, 5)) @(posedge sys_clk);
            #1 rsp_valid = 1'b1; rsp_data = rdata; r0 = rise_cnt;
            @(posedge sys_clk);
            #1 rsp_valid = 1'b0; rsp_data = 16'($urandom);
            if (mode == 3) begin
                check("ack_doe", D_OE, rnw);
                #2 nRESET = 1'b0;
                #1 check("nreset_async", {D_OUT, D_OE, nDTACK_OE, nBERR_OE, req_valid, bus_error}, 0);
                nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
                #20 nRESET = 1'b1;
                repeat (4) @(posedge sys_clk);
                @(posedge CLK_7M);
            end else begin
                for (int i = 0; i < 40 && !nDTACK_OE; i++) @(negedge sys_clk);
                check("dtack_seen", nDTACK_OE, 1);
                check("dtack_one_rise", rise_cnt - r0, 1);
                release_bus();
            end
        end
    endtask

    initial begin
        logic [23:0] a;
        nRESET = 1'b1; nRESET_BUS = 1'b1;
        nAS_IN = 1'b1; RnW_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        A_IN = '0; D_IN = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        #2 nRESET = 1'b0;
        #30 check("reset_outputs", {D_OUT, D_OE, nDTACK_OE, nBERR_OE, req_valid, req_addr,
                                    req_read, req_be, req_wdata, bus_error}, 0);
        #10 nRESET = 1'b1;
        repeat (2) @(posedge CLK_7M);

        do_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000, 2, 0, 16'hBEEF);
        do_cycle(24'hE90003, 1'b0, 2'b01, 16'h0042, 2, 0, 16'h0000);
        do_cycle(24'hF00000, 1'b1, 2'b11, 16'h0000, 2, 0, 16'h1111);
        do_cycle(24'hE90100, 1'b1, 2'b11, 16'h0000, 1, 1, 16'h1234);
        do_cycle(24'hE92468, 1'b1, 2'b10, 16'h0000, 140, 0, 16'hA55A);
        do_cycle(24'hE9ABCC, 1'b0, 2'b11, 16'hC0DE, 3, 2, 16'h0000);
        do_cycle(24'hE90020, 1'b1, 2'b11, 16'h0000, 0, 3, 16'h7E57);
        do_cycle(24'hE9FFFE, 1'b1, 2'b11, 16'h0000, 0, 0, 16'h0F0F);

        for (int n = 0; n < 24; n++) begin
            a = $urandom_range(0, 1) ? {8'hE9, 16'($urandom)} : 24'($urandom);
            do_cycle(a, 1'($urandom), 2'($urandom_range(1, 3)), 16'($urandom),
                     $urandom_range(0, 30), 0, 16'($urandom));
        end

        repeat (20) @(posedge sys_clk);
        check("req_q_empty", req_q.size(), 0);
        check("term_q_empty", term_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
